// File: rtl/cpu16_pkg.sv
// Shared widths and enums for the cpu16 register-file write path.
package cpu16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    NONE,
    MEM,
    ALU_HELD,
    ALU_DIRECT
  } wb_src_t;

  typedef enum logic {
    EMPTY,
    HELD
  } skid_state_t;

endpackage

// File: rtl/tag_fifo.sv
// Circular FIFO of load destination tags with a flat view of every slot and
// its valid bit. The caller guarantees push only when not full (or popping)
// and pop only when not empty.
module tag_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [DEPTH*WIDTH-1:0] entries_o,
  output logic [DEPTH-1:0]       valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_next(rd_ptr_q);
    end
    // A push into the slot being popped (full + pop) must leave it valid.
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_next(wr_ptr_q);
    end
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: tag storage is deliberately not reset; valid_q qualifies every slot,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    entries_o = '0;
    for (int i = 0; i < DEPTH; i++) entries_o[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_writeback.sv
// Single write port into the register file: merges in-order load returns with
// ALU results, tracks in-flight loads as a busy scoreboard, and serialises
// collisions through a one-entry skid buffer.
module regfile_writeback
  import cpu16_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluRd,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              LoadIssue,
  input  logic [ADDR_W-1:0] LoadRd,
  output logic              LoadReady,
  input  logic              MemValid,
  input  logic [DATA_W-1:0] MemData,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [NREG-1:0]   Busy,
  output logic              Error
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [QDEPTH*ADDR_W-1:0] fifo_entries;
  logic [QDEPTH-1:0]        fifo_valid;
  logic [ADDR_W-1:0]        head_tag;
  logic                     mem_write, load_push;

  skid_state_t       state_q, state_d;
  wb_src_t           wb_src;
  logic              alu_accept;
  logic [NREG-1:0]   busy;
  logic [ADDR_W-1:0] held_rd_q, rd_q;
  logic [DATA_W-1:0] held_data_q, wdata_q;
  logic              regwrite_q, error_q;

  assign mem_write = MemValid && !fifo_empty;
  // A full FIFO still takes a new tag when the head pops in the same cycle.
  assign load_push = LoadIssue && (!fifo_full || mem_write);

  tag_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_fifo (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .push_i    (load_push),
    .pop_i     (mem_write),
    .data_i    (LoadRd),
    .head_o    (head_tag),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .entries_o (fifo_entries),
    .valid_o   (fifo_valid)
  );

  always_comb begin
    busy = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (fifo_valid[i]) busy[fifo_entries[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (wb_src)
      MEM:      if (alu_accept) state_d = HELD;
      ALU_HELD: state_d = EMPTY;
      default:  state_d = state_q;
    endcase
  end

  // Stalling on a busy destination keeps ALU writes behind older loads.
  always_comb begin
    AluReady   = (state_q == EMPTY) && !busy[AluRd];
    alu_accept = AluValid && AluReady;
    if (mem_write)              wb_src = MEM;
    else if (state_q == HELD)   wb_src = ALU_HELD;
    else if (alu_accept)        wb_src = ALU_DIRECT;
    else                        wb_src = NONE;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      held_rd_q   <= '0;
      held_data_q <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      regwrite_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      regwrite_q <= (wb_src != NONE);
      unique case (wb_src)
        MEM: begin
          rd_q    <= head_tag;
          wdata_q <= MemData;
        end
        ALU_HELD: begin
          rd_q    <= held_rd_q;
          wdata_q <= held_data_q;
        end
        ALU_DIRECT: begin
          rd_q    <= AluRd;
          wdata_q <= AluData;
        end
        default: ;
      endcase
      if (wb_src == MEM && alu_accept) begin
        held_rd_q   <= AluRd;
        held_data_q <= AluData;
      end
      if (MemValid && fifo_empty) error_q <= 1'b1;
    end
  end

  assign LoadReady = (fifo_count < CNT_W'(QDEPTH));
  assign Busy      = busy;
  assign RD        = rd_q;
  assign WriteData = wdata_q;
  assign RegWrite  = regwrite_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a behavioural register file on
// the write port; expected values are hand-computed per step.
module tb_regfile_writeback;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        AluValid;
  logic [1:0]  AluRd;
  logic [15:0] AluData;
  logic        AluReady;
  logic        LoadIssue;
  logic [1:0]  LoadRd;
  logic        LoadReady;
  logic        MemValid;
  logic [15:0] MemData;
  logic [1:0]  RD;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [3:0]  Busy;
  logic        Error;

  logic [15:0] rf [4];
  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  regfile_writeback #(.QDEPTH(2)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .AluValid  (AluValid),
    .AluRd     (AluRd),
    .AluData   (AluData),
    .AluReady  (AluReady),
    .LoadIssue (LoadIssue),
    .LoadRd    (LoadRd),
    .LoadReady (LoadReady),
    .MemValid  (MemValid),
    .MemData   (MemData),
    .RD        (RD),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Busy      (Busy),
    .Error     (Error)
  );

  always @(posedge Clock) begin
    if (RegWrite) rf[RD] <= WriteData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    AluValid  = 1'b0;
    AluRd     = '0;
    AluData   = '0;
    LoadIssue = 1'b0;
    LoadRd    = '0;
    MemValid  = 1'b0;
    MemData   = '0;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 4; i++) rf[i] = '0;

    // Reset
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_regwrite_during", RegWrite, 0);
    end
    Reset_n = 1'b1;
    #1;
    check("rst_rd", RD, 0);
    check("rst_wdata", WriteData, 0);
    check("rst_busy", Busy, 0);
    check("rst_error", Error, 0);
    check("rst_aluready", AluReady, 1);
    check("rst_loadready", LoadReady, 1);
    tick();
    check("rst_regwrite_after", RegWrite, 0);

    // ALU write
    AluValid = 1'b1; AluRd = 2'd2; AluData = 16'd1;
    #1 check("alu_ready", AluReady, 1);
    tick();
    idle();
    check("alu_regwrite", RegWrite, 1);
    check("alu_rd", RD, 2);
    check("alu_wdata", WriteData, 16'd1);
    tick();
    check("alu_regwrite_drop", RegWrite, 0);
    check("alu_rd_hold", RD, 2);
    check("alu_wdata_hold", WriteData, 16'd1);
    check("rf_r2", rf[2], 16'd1);

    // Load, scoreboard, stalled ALU to the busy register
    LoadIssue = 1'b1; LoadRd = 2'd3;
    tick();
    idle();
    check("ld_busy", Busy, 4'b1000);
    AluValid = 1'b1; AluRd = 2'd3; AluData = 16'd7;
    #1 check("ld_alu_stalled", AluReady, 0);
    tick();
    check("ld_no_write", RegWrite, 0);
    MemValid = 1'b1; MemData = 16'd4;
    tick();
    MemValid = 1'b0; MemData = '0;
    check("ld_regwrite", RegWrite, 1);
    check("ld_rd", RD, 3);
    check("ld_wdata", WriteData, 16'd4);
    check("ld_busy_clear", Busy, 0);
    check("ld_alu_released", AluReady, 1);
    tick();
    idle();
    check("ld_alu_regwrite", RegWrite, 1);
    check("ld_alu_rd", RD, 3);
    check("ld_alu_wdata", WriteData, 16'd7);
    tick();
    check("rf_r3", rf[3], 16'd7);

    // Collision: load write wins, ALU result is held one cycle
    LoadIssue = 1'b1; LoadRd = 2'd1;
    tick();
    idle();
    check("col_busy", Busy, 4'b0010);
    MemValid = 1'b1; MemData = 16'hAAAA;
    AluValid = 1'b1; AluRd = 2'd0; AluData = 16'h5555;
    #1 check("col_alu_ready", AluReady, 1);
    tick();
    idle();
    check("col1_regwrite", RegWrite, 1);
    check("col1_rd", RD, 1);
    check("col1_wdata", WriteData, 16'hAAAA);
    check("col1_aluready_held", AluReady, 0);
    tick();
    check("col2_regwrite", RegWrite, 1);
    check("col2_rd", RD, 0);
    check("col2_wdata", WriteData, 16'h5555);
    check("col2_aluready", AluReady, 1);
    tick();
    check("col3_regwrite", RegWrite, 0);
    check("rf_r1", rf[1], 16'hAAAA);
    check("rf_r0", rf[0], 16'h5555);

    // FIFO full, then push together with pop
    LoadIssue = 1'b1; LoadRd = 2'd2;
    tick();
    LoadRd = 2'd0;
    tick();
    idle();
    check("full_loadready", LoadReady, 0);
    check("full_busy", Busy, 4'b0101);
    LoadIssue = 1'b1; LoadRd = 2'd1;
    MemValid = 1'b1; MemData = 16'h1234;
    tick();
    idle();
    check("fullpp_regwrite", RegWrite, 1);
    check("fullpp_rd", RD, 2);
    check("fullpp_wdata", WriteData, 16'h1234);
    check("fullpp_loadready", LoadReady, 0);
    check("fullpp_busy", Busy, 4'b0011);
    MemValid = 1'b1; MemData = 16'h0BBB;
    tick();
    check("drain1_rd", RD, 0);
    check("drain1_wdata", WriteData, 16'h0BBB);
    check("drain1_busy", Busy, 4'b0010);
    check("drain1_loadready", LoadReady, 1);
    MemData = 16'h0CCC;
    tick();
    idle();
    check("drain2_rd", RD, 1);
    check("drain2_wdata", WriteData, 16'h0CCC);
    check("drain2_busy", Busy, 0);

    // Error: return with nothing outstanding
    MemValid = 1'b1; MemData = 16'hDEAD;
    tick();
    idle();
    check("err_no_write", RegWrite, 0);
    check("err_set", Error, 1);
    check("err_rd_hold", RD, 1);
    tick();
    check("err_sticky", Error, 1);

    // Reset while a result is held and a load is queued
    LoadIssue = 1'b1; LoadRd = 2'd2;
    tick();
    LoadRd = 2'd3;
    tick();
    idle();
    MemValid = 1'b1; MemData = 16'h0D0D;
    AluValid = 1'b1; AluRd = 2'd0; AluData = 16'h0E0E;
    tick();
    idle();
    check("mid_held_rd", RD, 2);
    check("mid_held_aluready", AluReady, 0);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_regwrite", RegWrite, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_error", Error, 0);
    check("mid_rst_aluready", AluReady, 1);
    tick();
    check("mid_rst_regwrite2", RegWrite, 0);
    Reset_n = 1'b1;
    tick();
    check("post_rst_regwrite", RegWrite, 0);
    check("post_rst_rd", RD, 0);
    check("post_rst_wdata", WriteData, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
